prbs_test_ctrl: RTL
===================

PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 Parameter CHK_RST_CYC, default 16: cycles the checker reset is held per test.
REQ-002 Parameter LOCK_BEATS, default 64: consecutive error-free valid beats required to declare lock.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in LOCK before declaring lock failure.
REQ-004 rx_user_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rx_user_rstn_i  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  test start request, level-sampled.
REQ-007 abort_i  in  1  abort the running test.
REQ-008 window_i  in  32  measurement window length in valid beats; latched on start.
REQ-009 thr_i  in  16  max error beats for pass; latched on start.
REQ-010 rx_valid_i  in  1  valid beat on the checked datapath.
REQ-011 chk_err_i  in  1  OR-reduced checker mismatch, already aligned to rx_valid_i.
REQ-012 chk_rst_o  out  1  active-high reset to the PRBS checker.
REQ-013 busy_o  out  1  high in CLR, LOCK, MEAS.
REQ-014 done_o  out  1  one-cycle pulse on entry to DONE.
REQ-015 pass_o  out  1  test result, valid from done_o until next start.
REQ-016 lock_fail_o  out  1  lock timeout result, valid from done_o until next start.
REQ-017 err_cnt_o  out  16  error beats counted in MEAS.
REQ-018 beat_cnt_o  out  32  valid beats counted in MEAS.

Function
REQ-019 FSM states SHALL be IDLE, CLR, LOCK, MEAS, DONE, one state register.
REQ-020 IDLE or DONE with start_i=1 and abort_i=0 SHALL go to CLR next cycle, latch window_i (0 latched as 1) and thr_i, clear err_cnt_o, beat_cnt_o, pass_o, lock_fail_o.
REQ-021 start_i SHALL be ignored in CLR, LOCK, MEAS.
REQ-022 CLR SHALL drive chk_rst_o=1 for exactly CHK_RST_CYC cycles, then enter LOCK; chk_rst_o=0 in all other states.
REQ-023 LOCK: a valid beat with chk_err_i=0 increments the run counter; a valid beat with chk_err_i=1 clears it; non-valid cycles hold it.
REQ-024 LOCK: run counter reaching LOCK_BEATS SHALL enter MEAS on the following cycle; the beat that completes the run is not counted in MEAS.
REQ-025 LOCK: a cycle counter started on LOCK entry reaching LOCK_TIMEOUT without lock SHALL enter DONE with lock_fail_o=1, pass_o=0; lock wins if both occur on the same cycle.
REQ-026 MEAS: each rx_valid_i beat SHALL increment beat_cnt_o; each valid beat with chk_err_i=1 SHALL increment err_cnt_o, saturating at 0xFFFF.
REQ-027 MEAS: the beat making beat_cnt_o equal the latched window SHALL be counted, then enter DONE next cycle with pass_o = (err_cnt_o <= latched thr), lock_fail_o=0.
REQ-028 chk_err_i with rx_valid_i=0 SHALL be ignored in all states.
REQ-029 abort_i=1 in CLR, LOCK, MEAS or DONE SHALL enter IDLE next cycle; counters hold, no done_o, pass_o=0, lock_fail_o=0; abort_i has priority over start_i.
REQ-030 DONE SHALL hold results and counters until start_i or abort_i.

Reset
REQ-031 rx_user_rstn_i=0 at a clock edge SHALL force IDLE, chk_rst_o=1, busy_o=0, done_o=0, pass_o=0, lock_fail_o=0, err_cnt_o=0, beat_cnt_o=0, all internal counters 0, regardless of state.
REQ-032 First cycle after reset release SHALL show chk_rst_o=0 in IDLE.

Verification
REQ-033 start with window=1000, thr=0, clean data -> chk_rst_o high 16 cycles, lock after 64 beats, done_o after 1000 MEAS beats, pass_o=1, err_cnt_o=0, beat_cnt_o=1000.
REQ-034 Same, 3 injected error beats in MEAS, thr=2 -> pass_o=0, err_cnt_o=3; rerun with thr=3 -> pass_o=1.
REQ-035 Error beat every 32 valid beats through LOCK -> lock_fail_o=1, pass_o=0, done_o exactly 4096 cycles after LOCK entry.
REQ-036 abort_i mid-MEAS at beat 500 -> IDLE next cycle, no done_o, beat_cnt_o=500; start_i during MEAS without abort -> no effect.
REQ-037 Reset asserted in LOCK and in MEAS -> all outputs per REQ-031 next cycle; window_i=0 -> done_o after exactly 1 MEAS beat.
REQ-038 Error beats continuously in MEAS over 70000-beat window -> err_cnt_o saturates at 0xFFFF, pass_o=0.

Source files
------------

// File: rtl/prbs_test_ctrl.sv
// ----------------------------------------------------------------------------
// prbs_test_ctrl
// Sequencer for a PRBS link test on the recovered RX user clock. One test
// runs as follows:
//   1. Hold the PRBS checker in reset.
//   2. Wait until the checker reports LOCK_BEATS consecutive clean beats,
//      giving up after LOCK_TIMEOUT cycles.
//   3. Count valid beats and error beats over a window latched at start.
//   4. Report pass/fail against an error threshold latched at start.
// Every output is driven from a flop.
// ----------------------------------------------------------------------------
module prbs_test_ctrl #(
  parameter int CHK_RST_CYC  = 16,
  parameter int LOCK_BEATS   = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        rx_user_clk_i,
  input  logic        rx_user_rstn_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] window_i,
  input  logic [15:0] thr_i,
  input  logic        rx_valid_i,
  input  logic        chk_err_i,
  output logic        chk_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        lock_fail_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] beat_cnt_o
);

  // Counter widths are sized to hold their terminal values.
  localparam int CLR_W = $clog2(CHK_RST_CYC + 1);
  localparam int RUN_W = $clog2(LOCK_BEATS + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  // Terminal values are "last value before the event". Each transition is
  // taken on the edge that completes the count, so the next state begins on
  // the following cycle.
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CHK_RST_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_BEATS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]      ERR_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOCK = 3'd2,
    S_MEAS = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      win_lat;
  logic [15:0]      thr_lat;

  logic             good_beat;
  logic             bad_beat;
  logic             clr_last;
  logic             lock_hit;
  logic             tmo_hit;
  logic             win_hit;
  logic [15:0]      err_next;
  logic             meas_pass;
  logic [31:0]      win_start;

  // Saturating increment for the 16-bit error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == ERR_MAX) ? v : (v + 16'd1);
  endfunction

  // Decode of beat qualifiers and counter terminal conditions.
  always_comb begin
    good_beat = rx_valid_i & ~chk_err_i;
    bad_beat  = rx_valid_i &  chk_err_i;
    clr_last  = (clr_cnt == CLR_LAST);
    // The beat that completes the clean run triggers lock.
    lock_hit  = good_beat & (run_cnt == RUN_LAST);
    tmo_hit   = (tmo_cnt == TMO_LAST);
    // win_lat is never 0, so the decrement cannot wrap.
    win_hit   = rx_valid_i & (beat_cnt_o == (win_lat - 32'd1));
    err_next  = bad_beat ? sat_inc16(err_cnt_o) : err_cnt_o;
    // Pass compares the count that includes the final beat's error.
    meas_pass = (err_next <= thr_lat);
    // A zero window would never terminate, so it runs as a one-beat window.
    win_start = (window_i == 32'd0) ? 32'd1 : window_i;
  end

  // Test sequencer FSM: state, internal counters and all registered outputs.
  always_ff @(posedge rx_user_clk_i) begin
    if (!rx_user_rstn_i) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      run_cnt     <= '0;
      tmo_cnt     <= '0;
      win_lat     <= 32'd0;
      thr_lat     <= 16'd0;
      chk_rst_o   <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      lock_fail_o <= 1'b0;
      err_cnt_o   <= 16'd0;
      beat_cnt_o  <= 32'd0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        // Abort beats start and leaves the counters frozen for inspection.
        state       <= S_IDLE;
        chk_rst_o   <= 1'b0;
        busy_o      <= 1'b0;
        pass_o      <= 1'b0;
        lock_fail_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              state       <= S_CLR;
              clr_cnt     <= '0;
              win_lat     <= win_start;
              thr_lat     <= thr_i;
              chk_rst_o   <= 1'b1;
              busy_o      <= 1'b1;
              pass_o      <= 1'b0;
              lock_fail_o <= 1'b0;
              err_cnt_o   <= 16'd0;
              beat_cnt_o  <= 32'd0;
            end else begin
              chk_rst_o <= 1'b0;
              busy_o    <= 1'b0;
            end
          end

          S_CLR: begin
            if (clr_last) begin
              state     <= S_LOCK;
              chk_rst_o <= 1'b0;
              run_cnt   <= '0;
              tmo_cnt   <= '0;
            end else begin
              clr_cnt   <= clr_cnt + CLR_W'(1);
            end
          end

          S_LOCK: begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (good_beat) begin
              run_cnt <= run_cnt + RUN_W'(1);
            end else if (bad_beat) begin
              run_cnt <= '0;
            end else begin
              run_cnt <= run_cnt;
            end
            // Lock is checked first, so it wins a same-cycle timeout.
            if (lock_hit) begin
              state <= S_MEAS;
            end else if (tmo_hit) begin
              state       <= S_DONE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              pass_o      <= 1'b0;
              lock_fail_o <= 1'b1;
            end else begin
              state <= S_LOCK;
            end
          end

          S_MEAS: begin
            if (rx_valid_i) begin
              beat_cnt_o <= beat_cnt_o + 32'd1;
              err_cnt_o  <= err_next;
            end else begin
              beat_cnt_o <= beat_cnt_o;
              err_cnt_o  <= err_cnt_o;
            end
            if (win_hit) begin
              state       <= S_DONE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              pass_o      <= meas_pass;
              lock_fail_o <= 1'b0;
            end else begin
              state <= S_MEAS;
            end
          end

          default: begin
            state     <= S_IDLE;
            chk_rst_o <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
